// File: rtl/sram_blwl_programmer_if.sv
// Handshake and array-drive bundle between the configuration loader and the BL/WL programmer.
// Carries no state and adds no latency.
// The loader side holds cfg_valid/cfg_data until cfg_ready; the programmer side drives the array lines.
interface sram_blwl_programmer_if #(
  parameter int NUM_BL = 8,
  parameter int NUM_WL = 16,
  parameter int ADDR_W = 4
);

  // sweep control from the loader
  logic              start;
  logic              abort;

  // row data handshake
  logic              cfg_valid;
  logic [NUM_BL-1:0] cfg_data;
  logic              cfg_ready;

  // array drive and status
  logic [NUM_BL-1:0] bl;
  logic [NUM_WL-1:0] wl;
  logic [ADDR_W-1:0] row_addr;
  logic              busy;
  logic              done;

  // loader / testbench side
  modport master (
    output start, abort, cfg_valid, cfg_data,
    input  cfg_ready, bl, wl, row_addr, busy, done
  );

  // programmer side
  modport slave (
    input  start, abort, cfg_valid, cfg_data,
    output cfg_ready, bl, wl, row_addr, busy, done
  );

endinterface

// File: rtl/sram_blwl_programmer.sv
// Write-side driver for a BL/WL configuration SRAM: one row per handshake, rows 0..NUM_WL-1 in order.
// Per row: SETUP_CYC cycles bl setup, PULSE_CYC cycles wl high, HOLD_CYC cycles bl hold; row period SETUP+PULSE+HOLD+1.
// cfg_ready is asserted only while waiting for a row; a low cfg_valid stalls with wl=0 and bl=0 indefinitely.
module sram_blwl_programmer #(
  parameter int NUM_BL    = 8,
  parameter int NUM_WL    = 16,
  parameter int ADDR_W    = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_blwl_programmer_if.slave bus
);

  // Phase counter is sized for the longest of the three timed phases.
  localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int CW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  // Terminal counts: the counter restarts at 0 on every state entry.
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_WL - 1);
  localparam logic [NUM_WL-1:0] WL_ONE   = NUM_WL'(1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WAIT  = 3'd1;
  localparam logic [2:0] SETUP = 3'd2;
  localparam logic [2:0] PULSE = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  logic [2:0]        state_q,  state_nxt;
  logic [CW-1:0]     phase_q,  phase_nxt;
  logic [ADDR_W-1:0] row_q,    row_nxt;
  logic [NUM_BL-1:0] bl_q,     bl_nxt;
  logic [NUM_WL-1:0] wl_q,     wl_nxt;
  logic              done_q,   done_nxt;
  logic [NUM_WL-1:0] wl_row;

  // Word-line pattern for the row being programmed.
  assign wl_row = WL_ONE << row_q;

  // Next-state logic: abort outranks handshake and phase advance in every busy state.
  always_comb begin
    state_nxt = state_q;
    phase_nxt = phase_q;
    row_nxt   = row_q;
    bl_nxt    = bl_q;
    wl_nxt    = '0;
    done_nxt  = 1'b0;

    if (state_q == IDLE) begin
      // start with abort in the same cycle is treated as no request
      if (bus.start && !bus.abort) begin
        state_nxt = WAIT;
        phase_nxt = '0;
        row_nxt   = '0;
        bl_nxt    = '0;
      end
    end else if (bus.abort) begin
      // cancel: lines released next edge, no done, rows already written stay written
      state_nxt = IDLE;
      phase_nxt = '0;
      row_nxt   = '0;
      bl_nxt    = '0;
    end else begin
      case (state_q)
        WAIT: begin
          if (bus.cfg_valid) begin
            state_nxt = SETUP;
            phase_nxt = '0;
            bl_nxt    = bus.cfg_data;
          end
        end

        SETUP: begin
          if (phase_q == SETUP_LAST) begin
            state_nxt = PULSE;
            phase_nxt = '0;
            wl_nxt    = wl_row;
          end else begin
            phase_nxt = phase_q + CW'(1);
          end
        end

        PULSE: begin
          if (phase_q == PULSE_LAST) begin
            // wl drops on entry to HOLD while bl stays put
            state_nxt = HOLD;
            phase_nxt = '0;
          end else begin
            phase_nxt = phase_q + CW'(1);
            wl_nxt    = wl_row;
          end
        end

        HOLD: begin
          if (phase_q == HOLD_LAST) begin
            phase_nxt = '0;
            bl_nxt    = '0;
            if (row_q == LAST_ROW) begin
              // row_addr is left at the last row; it never wraps
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = WAIT;
              row_nxt   = row_q + ADDR_W'(1);
            end
          end else begin
            phase_nxt = phase_q + CW'(1);
          end
        end

        default: begin
          // unreachable encodings recover to a quiet IDLE
          state_nxt = IDLE;
          phase_nxt = '0;
          row_nxt   = '0;
          bl_nxt    = '0;
        end
      endcase
    end
  end

  // State and line registers; async reset forces wl low immediately so it cannot glitch high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      row_q   <= '0;
      bl_q    <= '0;
      wl_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      phase_q <= phase_nxt;
      row_q   <= row_nxt;
      bl_q    <= bl_nxt;
      wl_q    <= wl_nxt;
      done_q  <= done_nxt;
    end
  end

  // Status decodes come straight from the state register, never from cfg_valid.
  assign bus.cfg_ready = (state_q == WAIT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.bl        = bl_q;
  assign bus.wl        = wl_q;
  assign bus.row_addr  = row_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sram_blwl_programmer.sv
// Bench for sram_blwl_programmer: directed scenarios plus randomized traffic against a row-timeline model.
// The model tracks only "busy / row / cycles since row accepted" and derives every line from that.
// All outputs are compared on every falling clock edge; inputs change 1 time unit after rising edges.
module tb_sram_blwl_programmer;

  localparam int NBL = 8;
  localparam int NWL = 16;
  localparam int AW  = 4;
  localparam int S   = 1;
  localparam int P   = 2;
  localparam int H   = 1;
  localparam int T   = S + P + H;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_err    = 0;

  sram_blwl_programmer_if #(.NUM_BL(NBL), .NUM_WL(NWL), .ADDR_W(AW)) bus ();

  sram_blwl_programmer #(
    .NUM_BL(NBL), .NUM_WL(NWL), .ADDR_W(AW),
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [NWL-1:0] v);
    int idx = -1;
    int cnt = 0;
    for (int i = 0; i < NWL; i++) if (v[i]) begin idx = i; cnt++; end
    return (cnt > 1) ? 99 : idx;
  endfunction

  // ---------------- behavioural model ----------------
  bit             m_busy  = 0;
  bit             m_inrow = 0;
  int             m_row   = 0;
  int             m_t     = 0;
  logic [NBL-1:0] m_data  = '0;
  bit             m_done  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_inrow = 0; m_row = 0; m_t = 0; m_data = '0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (bus.start && !bus.abort) begin m_busy = 1; m_row = 0; m_inrow = 0; end
      end else if (bus.abort) begin
        m_busy = 0; m_row = 0; m_inrow = 0;
      end else if (!m_inrow) begin
        if (bus.cfg_valid) begin m_inrow = 1; m_t = 0; m_data = bus.cfg_data; end
      end else begin
        m_t++;
        if (m_t == T) begin
          m_inrow = 0;
          if (m_row == NWL - 1) begin m_busy = 0; m_done = 1; end
          else m_row++;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [NWL-1:0] e_wl;
    logic [NBL-1:0] e_bl;
    e_wl = (m_busy && m_inrow && m_t >= S && m_t < S + P) ? (NWL'(1) << m_row) : '0;
    e_bl = (m_busy && m_inrow) ? m_data : '0;
    check("model_wl",        32'(bus.wl),        32'(e_wl));
    check("model_bl",        32'(bus.bl),        32'(e_bl));
    check("model_cfg_ready", 32'(bus.cfg_ready), 32'(m_busy && !m_inrow));
    check("model_busy",      32'(bus.busy),      32'(m_busy));
    check("model_done",      32'(bus.done),      32'(m_done));
    check("model_row_addr",  32'(bus.row_addr),  32'(m_row));
  end

  // ---------------- stimulus ----------------
  initial begin
    int pstart[$];
    int pidx[$];
    int pwid[$];
    int pbl[$];
    logic [NWL-1:0] prev;
    int dcnt;
    bit found;
    bit ok;

    bus.start = 0; bus.abort = 0; bus.cfg_valid = 0; bus.cfg_data = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wl",        32'(bus.wl),        0);
    check("rst_bl",        32'(bus.bl),        0);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 0);
    check("rst_busy",      32'(bus.busy),      0);
    check("rst_done",      32'(bus.done),      0);
    check("rst_row_addr",  32'(bus.row_addr),  0);
    rst_n = 1'b1;
    tick();

    // ---- single row timing with A5 ----
    bus.start = 1; tick(); bus.start = 0;
    check("t2_busy", 32'(bus.busy), 1);
    check("t2_ready", 32'(bus.cfg_ready), 1);
    bus.cfg_valid = 1; bus.cfg_data = 8'hA5; tick(); bus.cfg_valid = 0;
    check("t2_setup_bl", 32'(bus.bl), 32'h A5);
    check("t2_setup_wl", 32'(bus.wl), 0);
    check("t2_setup_ready", 32'(bus.cfg_ready), 0);
    tick();
    check("t2_pulse1_wl", 32'(bus.wl), 32'h0001);
    check("t2_pulse1_bl", 32'(bus.bl), 32'hA5);
    tick();
    check("t2_pulse2_wl", 32'(bus.wl), 32'h0001);
    tick();
    check("t2_hold_wl", 32'(bus.wl), 0);
    check("t2_hold_bl", 32'(bus.bl), 32'hA5);
    tick();
    check("t2_next_bl", 32'(bus.bl), 0);
    check("t2_next_ready", 32'(bus.cfg_ready), 1);
    check("t2_next_row", 32'(bus.row_addr), 1);
    check("t2_no_done", 32'(bus.done), 0);

    // ---- async reset during PULSE of row 1 ----
    bus.cfg_valid = 1; bus.cfg_data = 8'h3C; tick(); bus.cfg_valid = 0;
    tick();
    check("t1_pulse_wl", 32'(bus.wl), 32'h0002);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_wl", 32'(bus.wl), 0);
    check("t1_async_bl", 32'(bus.bl), 0);
    check("t1_async_busy", 32'(bus.busy), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    check("t1_post_busy", 32'(bus.busy), 0);
    check("t1_post_ready", 32'(bus.cfg_ready), 0);
    check("t1_post_row", 32'(bus.row_addr), 0);

    // ---- full sweep, valid always high, data = row index ----
    bus.start = 1; tick(); bus.start = 0;
    bus.cfg_valid = 1; bus.cfg_data = 8'(bus.row_addr);
    prev = '0; dcnt = 0;
    for (int c = 0; c < 120 && dcnt == 0; c++) begin
      tick();
      bus.cfg_data = 8'(bus.row_addr);
      if (bus.wl != 0 && prev == 0) begin
        pstart.push_back(c); pidx.push_back(idx_of(bus.wl)); pbl.push_back(int'(bus.bl));
      end
      if (bus.wl == 0 && prev != 0 && pstart.size() > 0) pwid.push_back(c - pstart[$]);
      if (bus.done) begin
        dcnt++;
        check("t3_busy_with_done", 32'(bus.busy), 0);
      end
      prev = bus.wl;
    end
    bus.cfg_valid = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (bus.done) dcnt++; end
    check("t3_done_count", dcnt, 1);
    check("t3_pulse_count", pidx.size(), NWL);
    check("t3_width_count", pwid.size(), NWL);
    for (int i = 0; i < NWL && i < pidx.size(); i++) begin
      check("t3_order", pidx[i], i);
      check("t3_bl", pbl[i], i);
      if (i < pwid.size()) check("t3_width", pwid[i], P);
      if (i > 0) check("t3_spacing", pstart[i] - pstart[i-1], T + 1);
    end

    // ---- backpressure at row 3 ----
    bus.start = 1; tick(); bus.start = 0;
    bus.cfg_valid = 1; bus.cfg_data = 8'h5A;
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      tick();
      if (bus.row_addr == 3 && bus.cfg_ready) found = 1;
    end
    check("t4_reach_row3", found, 1);
    bus.cfg_valid = 0;
    ok = 1;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (!(bus.cfg_ready == 1 && bus.wl == 0 && bus.bl == 0 && bus.row_addr == 3)) ok = 0;
    end
    check("t4_stall", ok, 1);
    bus.cfg_valid = 1; bus.cfg_data = 8'hC3; tick(); bus.cfg_valid = 0;
    check("t4_setup_wl", 32'(bus.wl), 0);
    check("t4_setup_bl", 32'(bus.bl), 32'hC3);
    tick();
    check("t4_pulse_wl", 32'(bus.wl), 32'h0008);
    bus.abort = 1; tick(); bus.abort = 0;

    // ---- abort on first PULSE cycle of row 5 ----
    bus.start = 1; tick(); bus.start = 0;
    bus.cfg_valid = 1;
    found = 0;
    for (int c = 0; c < 80 && !found; c++) begin
      bus.cfg_data = 8'($urandom);
      tick();
      if (bus.row_addr == 5 && bus.wl != 0) found = 1;
    end
    check("t5_reach_pulse5", found, 1);
    check("t5_pulse5_wl", 32'(bus.wl), 32'h0020);
    bus.abort = 1; tick(); bus.abort = 0;
    check("t5_wl", 32'(bus.wl), 0);
    check("t5_bl", 32'(bus.bl), 0);
    check("t5_busy", 32'(bus.busy), 0);
    check("t5_row", 32'(bus.row_addr), 0);
    check("t5_done", 32'(bus.done), 0);
    bus.start = 1; tick(); bus.start = 0;
    check("t5_restart_busy", 32'(bus.busy), 1);
    check("t5_restart_row", 32'(bus.row_addr), 0);

    // ---- start while busy at row 2 ----
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (bus.row_addr == 2 && bus.cfg_ready) found = 1;
    end
    check("t6_reach_row2", found, 1);
    bus.start = 1; tick(); bus.start = 0;
    check("t6_row_kept", 32'(bus.row_addr), 2);
    check("t6_busy", 32'(bus.busy), 1);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (bus.row_addr == 3) found = 1;
    end
    check("t6_row3", found, 1);
    found = 0;
    for (int c = 0; c < 120 && !found; c++) begin
      tick();
      if (bus.done) found = 1;
    end
    check("t6_done", found, 1);
    check("t6_done_row", 32'(bus.row_addr), NWL - 1);
    bus.cfg_valid = 0;

    // ---- randomized traffic ----
    for (int c = 0; c < 3000; c++) begin
      bus.start     = ($urandom_range(0, 9) == 0);
      bus.abort     = ($urandom_range(0, 299) == 0);
      bus.cfg_valid = ($urandom_range(0, 9) < 7);
      bus.cfg_data  = 8'($urandom);
      tick();
    end
    bus.start = 0; bus.abort = 0; bus.cfg_valid = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
